csa_accumulator: RTL and testbench
==================================

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameter W, default 4: operand width in bits.
REQ-002 Parameter AW, default 8: accumulator and result width; SHALL equal 2*W.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 in_data  input  W  unsigned operand.
REQ-008 in_last  input  1  marks the final operand of a group; qualified by in_valid && in_ready.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  AW  resolved group sum, modulo 2^AW.
REQ-012 out_ovf  output  1  true group sum was 2^AW or greater.

Function
REQ-013 Internal state: redundant sum vector S[AW-1:0], carry vector C[AW-1:0], sticky overflow flag V, low-nibble result register, carry register c_mid, and state register with states ACCUM, RES_LO, RES_HI and OUT.
REQ-014 A beat is accepted when in_valid and in_ready are both 1 at a rising edge; in_ready SHALL be 1 only in ACCUM.
REQ-015 On accept, compress S, C and the zero-extended X=in_data with a 3:2 carry-save step: S <= S^C^X; C <= {maj(S,C,X)[AW-2:0], 0}.
REQ-016 On accept, V <= V | maj(S,C,X)[AW-1]; the carry shifted out of the top bit SHALL be recorded, never silently dropped.
REQ-017 Accept with in_last=0: remain in ACCUM. Accept with in_last=1: apply REQ-015/016, then go to RES_LO.
REQ-018 RES_LO, one cycle: {c_mid, lo} <= S[W-1:0] + C[W-1:0]; go to RES_HI; in_data is ignored.
REQ-019 RES_HI, one cycle: {co, hi} = S[AW-1:W] + C[AW-1:W] + c_mid; result <= {hi, lo}; V <= V | co; go to OUT.
REQ-020 Resolution SHALL use two W-bit ripple slices with inter-slice carry c_mid. No single AW-bit adder is permitted.
REQ-021 OUT: out_valid=1; out_sum and out_ovf SHALL be held stable until out_valid && out_ready.
REQ-022 Handshake in OUT: S, C and V are cleared to 0 and the block returns to ACCUM. in_ready rises in the following cycle.
REQ-023 out_valid SHALL be 0 in every state except OUT.
REQ-024 Latency: the last beat is accepted at edge N; out_valid is first high in the cycle after edge N+2, which is 3 edges to result.
REQ-025 Throughput: a group of k operands occupies at least k+3 cycles; no overlap between groups.
REQ-026 Correctness invariant: true_sum = S + C + 2^AW * (count of recorded overflow carries).
REQ-027 Result: out_sum = true_sum mod 2^AW; out_ovf = (true_sum >= 2^AW).
REQ-028 A group of one beat with in_last=1 SHALL be valid and produce out_sum = in_data.
REQ-029 in_valid=0 in ACCUM: state is held; no implicit zero operand is added.
REQ-030 out_ready=1 while out_valid=0 has no effect.

Reset
REQ-031 At a rising edge with rst_n=0, regardless of state (including mid-group, RES_LO, RES_HI and OUT):
- state <= ACCUM
- S, C, V, lo, c_mid and result <= 0
REQ-032 Output values while rst_n=0 and in the cycle after reset: in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-033 A partially accumulated group interrupted by reset SHALL be discarded; no result is produced for it.

Verification
REQ-034 Beats 5, 7, 9 (last on 9), out_ready=1 -> out_sum=21, out_ovf=0; out_valid rises 3 edges after the accept of 9 and is high one cycle.
REQ-035 Single beat 15 with in_last=1 -> out_sum=15, out_ovf=0; then beat 3 with last -> out_sum=3, confirming the clear.
REQ-036 17 beats of 15 -> out_sum=255, out_ovf=0; 18 beats of 15 -> out_sum=14, out_ovf=1 (270-256).
REQ-037 Beats 8, 8 (last); out_ready held 0 for 5 cycles after out_valid -> out_sum=16 stable and in_ready=0 throughout; pulse out_ready -> in_ready=1 the next cycle.
REQ-038 Random in_valid gaps and random in_data, 1-20 beats per group, 200 groups -> out_sum and out_ovf match the reference model per REQ-027.
REQ-039 Reset during RES_LO of group (9, 9) -> out_valid stays 0; next group containing only 4 -> out_sum=4, out_ovf=0.

Source files
------------

// File: rtl/csa_accumulator.sv
// Carry-save group accumulator.
// Operands are folded into a redundant sum/carry pair with one 3:2 compression
// per accepted beat. At the end of a group, the pair is resolved over two
// cycles by two W-bit ripple slices. The result is then held until the
// downstream side takes it.
module csa_accumulator #(
  parameter int W  = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf
);

  typedef enum logic [1:0] {ACCUM, RES_LO, RES_HI, OUT} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] s, c, result;
  logic          v, c_mid;
  logic [W-1:0]  lo;

  logic [AW-1:0] x, maj;
  logic [W:0]    lo_sum, hi_sum;
  logic          accept, handshake;

  // Bitwise majority: the carry vector of a 3:2 compressor.
  function automatic logic [AW-1:0] maj3(input logic [AW-1:0] a,
                                         input logic [AW-1:0] b,
                                         input logic [AW-1:0] d);
    return (a & b) | (a & d) | (b & d);
  endfunction

  // One W-bit ripple slice with carry in and carry out (the MSB of the result).
  function automatic logic [W:0] add_slice(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  assign x         = {{(AW-W){1'b0}}, in_data};
  assign maj       = maj3(s, c, x);
  assign lo_sum    = add_slice(s[W-1:0], c[W-1:0], 1'b0);
  assign hi_sum    = add_slice(s[AW-1:W], c[AW-1:W], c_mid);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign out_sum   = result;
  assign out_ovf   = v;

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = RES_LO;
      end
      RES_LO: state_nxt = RES_HI;
      RES_HI: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Datapath registers: compress on accept, resolve low then high slice, then
  // clear the accumulator once the result has been taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s      <= '0;
      c      <= '0;
      v      <= 1'b0;
      lo     <= '0;
      c_mid  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s <= s ^ c ^ x;
            c <= {maj[AW-2:0], 1'b0};
            // Carry leaving the top bit is worth 2^AW; keep it as overflow.
            v <= v | maj[AW-1];
          end
        end
        RES_LO: begin
          {c_mid, lo} <= lo_sum;
        end
        RES_HI: begin
          result <= {hi_sum[W-1:0], lo};
          v      <= v | hi_sum[W];
        end
        OUT: begin
          if (handshake) begin
            s <= '0;
            c <= '0;
            v <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: directed vector table, hand-written
// stall and reset sequences, then randomized groups compared with an
// arithmetic reference model.
module tb_csa_accumulator;

  localparam int W  = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;

  int checks = 0;
  int errors = 0;

  csa_accumulator #(.W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  n;
    logic [19:0][W-1:0]  d;
    logic [AW-1:0]       sum;
    logic                ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive n beats starting at a negedge; returns at the negedge after the
  // edge that accepted the last beat.
  task automatic send_group(input int n, input logic [19:0][W-1:0] d,
                            input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = d[i];
      in_last  = (i == n - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the negedge just after the last beat was accepted.
  task automatic get_result(input string name, input logic [AW-1:0] es,
                            input logic eo, input int stall);
    int lat;
    out_ready = (stall == 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_sum"}, out_sum, es);
    chk({name, "_ovf"}, out_ovf, eo);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (out_sum != es || out_ovf != eo || !out_valid || in_ready)
        chk({name, "_hold"}, {out_valid, in_ready, out_ovf, out_sum}, {2'b10, eo, es});
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid || !in_ready)
      chk({name, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [19:0][W-1:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Directed table.
    tbl[0].n = 3;  tbl[0].d = '0; tbl[0].d[0] = 4'd5; tbl[0].d[1] = 4'd7; tbl[0].d[2] = 4'd9;
    tbl[0].sum = 8'd21;  tbl[0].ovf = 1'b0;
    tbl[1].n = 1;  tbl[1].d = '0; tbl[1].d[0] = 4'd15; tbl[1].sum = 8'd15; tbl[1].ovf = 1'b0;
    tbl[2].n = 1;  tbl[2].d = '0; tbl[2].d[0] = 4'd3;  tbl[2].sum = 8'd3;  tbl[2].ovf = 1'b0;
    tbl[3].n = 17; tbl[3].d = {20{4'hF}}; tbl[3].sum = 8'd255; tbl[3].ovf = 1'b0;
    tbl[4].n = 18; tbl[4].d = {20{4'hF}}; tbl[4].sum = 8'd14;  tbl[4].ovf = 1'b1;
    tbl[5].n = 20; tbl[5].d = {20{4'hF}}; tbl[5].sum = 8'd44;  tbl[5].ovf = 1'b1;

    // Reset state, both during and after reset.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    for (int i = 0; i < 6; i++) begin
      send_group(tbl[i].n, tbl[i].d, 1'b0);
      get_result($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].ovf, 0);
    end

    // Backpressure: result must hold while out_ready is low.
    d = '0; d[0] = 4'd8; d[1] = 4'd8;
    send_group(2, d, 1'b0);
    get_result("stall", 8'd16, 1'b0, 5);

    // Reset while resolving: group is dropped.
    d = '0; d[0] = 4'd9; d[1] = 4'd9;
    send_group(2, d, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_drop_valid", out_valid, 0);
      @(negedge clk);
    end
    chk("rst_drop_in_ready", in_ready, 1);
    d = '0; d[0] = 4'd4;
    send_group(1, d, 1'b0);
    get_result("after_rst", 8'd4, 1'b0, 0);

    // Randomized groups against an arithmetic model.
    for (int g = 0; g < 200; g++) begin
      int n;
      int total;
      n = $urandom_range(1, 20);
      total = 0;
      d = '0;
      for (int i = 0; i < n; i++) begin
        d[i] = W'($urandom_range(0, 15));
        total += int'(d[i]);
      end
      send_group(n, d, 1'b1);
      get_result($sformatf("rnd%0d", g), AW'(total % 256), (total >= 256),
                 $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
